// File: rtl/fpga_sram_spi_preload.sv
`default_nettype none
// ============================================================================
//  Module   : fpga_sram_spi_preload
//  Purpose  : Boot-time loader for the FPGA block-RAM SRAM. After reset it
//             reads a 2**AW-word image from an SPI NOR flash (READ 0x03,
//             SPI mode 0) and writes it into the SRAM one full word at a
//             time. When the copy is done, it hands the SRAM port to the bus
//             side.
//  Ports    : CLK, RESETn           clock, async active-low reset
//             BUS_*                 system bus side of the SRAM port
//             SRAM_*                physical SRAM port (1-cycle read latency)
//             SPI_CS_N/SCLK/MOSI/MISO  flash interface
//             PRELOAD_BUSY/DONE     loader status
//             PRELOAD_CSUM          image checksum (zero unless enabled)
//  Options  : `define FPGA_SRAM_PRELOAD_CSUM_EN builds a 32-bit additive
//             checksum of every word written by the loader.
//  Revision : 1.0  initial release
// ============================================================================
module fpga_sram_spi_preload #(
   parameter int          AW         = 16,
   parameter logic [23:0] FLASH_BASE = 24'h000000,
   parameter int          CLKDIV     = 2
) (
   input  logic          CLK,
   input  logic          RESETn,
   input  logic [AW-1:0] BUS_ADDR,
   input  logic [31:0]   BUS_WDATA,
   input  logic [3:0]    BUS_WREN,
   input  logic          BUS_CS,
   output logic [31:0]   BUS_RDATA,
   output logic [AW-1:0] SRAM_ADDR,
   output logic [31:0]   SRAM_WDATA,
   output logic [3:0]    SRAM_WREN,
   output logic          SRAM_CS,
   input  logic [31:0]   SRAM_RDATA,
   output logic          SPI_CS_N,
   output logic          SPI_SCLK,
   output logic          SPI_MOSI,
   input  logic          SPI_MISO,
   output logic          PRELOAD_BUSY,
   output logic          PRELOAD_DONE,
   output logic [31:0]   PRELOAD_CSUM
);

   localparam logic [31:0] c_CMD      = {8'h03, FLASH_BASE};
   localparam logic [7:0]  c_DIV_LAST = 8'(CLKDIV - 1);
   localparam logic [AW:0] c_LAST     = {1'b0, {AW{1'b1}}};
   localparam logic [AW:0] c_WCNT_INC = {{AW{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [7:0]  r_div;       // cycles elapsed in the current SCLK phase
   logic [4:0]  r_bitcnt;    // bits completed in the current 32-bit frame
   logic        r_sclk;
   logic        r_mosi;
   logic        r_cs_n;
   logic [31:0] r_tx;        // remaining command bits, next bit in [31]
   logic [31:0] r_rx;        // received bits, first byte ends up in [31:24]
   logic [AW:0] r_wcnt;      // one spare bit so the last-word test never wraps
   logic        r_bus_sel;

   logic        w_phase_end;
   logic        w_bit_done;
   logic        w_last_bit;
   logic        w_busy;
   logic        w_done;
   logic        w_ld_cs;
   logic        w_spi_active;
   logic [31:0] w_word;

   assign w_phase_end = (r_div == c_DIV_LAST);
   assign w_bit_done  = w_phase_end & r_sclk;     // end of a high phase
   assign w_last_bit  = (r_bitcnt == 5'd31);

   // Bytes arrive MSB-first in stream order; the first byte is the LSB.
   assign w_word = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and state-decoded outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      w_ld_cs     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_CMD;
         end
         ST_CMD: begin
            if (w_bit_done && w_last_bit) begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_bit_done && w_last_bit) begin
               w_state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            w_ld_cs     = 1'b1;
            w_state_nxt = (r_wcnt == c_LAST) ? ST_DONE : ST_DATA;
         end
         ST_DONE: begin
            w_busy = 1'b0;
            w_done = 1'b1;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_spi_active = (w_state_nxt == ST_CMD) || (w_state_nxt == ST_DATA) ||
                         (w_state_nxt == ST_WRITE);

   // ------------------------------------------------------------------------
   // SPI bit engine and word counter
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_div    <= 8'd0;
         r_bitcnt <= 5'd0;
         r_sclk   <= 1'b0;
         r_mosi   <= 1'b0;
         r_cs_n   <= 1'b1;
         r_tx     <= 32'h0;
         r_rx     <= 32'h0;
         r_wcnt   <= '0;
      end else begin
         r_cs_n <= ~w_spi_active;
         case (r_state)
            ST_IDLE: begin
               // First command bit is on MOSI as CS_N falls.
               r_mosi   <= c_CMD[31];
               r_tx     <= {c_CMD[30:0], 1'b0};
               r_div    <= 8'd0;
               r_bitcnt <= 5'd0;
               r_sclk   <= 1'b0;
            end
            ST_CMD, ST_DATA: begin
               if (w_phase_end) begin
                  r_div <= 8'd0;
                  if (!r_sclk) begin
                     r_sclk <= 1'b1;
                     if (r_state == ST_DATA) begin
                        r_rx <= {r_rx[30:0], SPI_MISO};
                     end
                  end else begin
                     r_sclk   <= 1'b0;
                     r_bitcnt <= r_bitcnt + 5'd1;
                     if (w_last_bit || (r_state == ST_DATA)) begin
                        r_mosi <= 1'b0;
                     end else begin
                        r_mosi <= r_tx[31];
                        r_tx   <= {r_tx[30:0], 1'b0};
                     end
                  end
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            ST_WRITE: begin
               r_wcnt   <= r_wcnt + c_WCNT_INC;
               r_div    <= 8'd0;
               r_bitcnt <= 5'd0;
               r_sclk   <= 1'b0;
               r_mosi   <= 1'b0;
            end
            default: begin
               r_sclk <= 1'b0;
               r_mosi <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // SRAM port ownership and bus read return
   // ------------------------------------------------------------------------
   assign SRAM_CS    = w_busy ? w_ld_cs : BUS_CS;
   assign SRAM_WREN  = w_busy ? {4{w_ld_cs}} : BUS_WREN;
   assign SRAM_ADDR  = w_busy ? (w_ld_cs ? r_wcnt[AW-1:0] : '0) : BUS_ADDR;
   assign SRAM_WDATA = w_busy ? (w_ld_cs ? w_word : 32'h0) : BUS_WDATA;

   // Qualifying with the registered select keeps the read data of the final
   // loader write off the bus on the first DONE cycle.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_bus_sel <= 1'b0;
      end else begin
         r_bus_sel <= BUS_CS & ~w_busy;
      end
   end

   assign BUS_RDATA = r_bus_sel ? SRAM_RDATA : 32'h0;

   // ------------------------------------------------------------------------
   // Optional image checksum
   // ------------------------------------------------------------------------
`ifdef FPGA_SRAM_PRELOAD_CSUM_EN
   logic [31:0] r_csum;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_csum <= 32'h0;
      end else if (w_ld_cs) begin
         r_csum <= r_csum + w_word;
      end
   end

   assign PRELOAD_CSUM = r_csum;
`else
   assign PRELOAD_CSUM = 32'h0;
`endif

   assign SPI_CS_N     = r_cs_n;
   assign SPI_SCLK     = r_sclk;
   assign SPI_MOSI     = r_mosi;
   assign PRELOAD_BUSY = w_busy;
   assign PRELOAD_DONE = w_done;

endmodule
`default_nettype wire

// File: tb/tb_fpga_sram_spi_preload.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fpga_sram_spi_preload
//  Purpose  : Self-checking bench for fpga_sram_spi_preload with an SPI NOR
//             flash model, a registered-read SRAM model and scoreboards for
//             loader writes and bus reads.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpga_sram_spi_preload;

   localparam int          AW          = 4;
   localparam int          CLKDIV      = 2;
   localparam logic [23:0] FLASH_BASE  = 24'h010000;
   localparam int          NWORDS      = 1 << AW;
   localparam int          LOAD_CYCLES = 1 + 64*CLKDIV + NWORDS*(64*CLKDIV + 1);

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          CLK = 1'b0;
   logic          RESETn = 1'b0;
   logic [AW-1:0] BUS_ADDR = '0;
   logic [31:0]   BUS_WDATA = 32'h0;
   logic [3:0]    BUS_WREN = 4'h0;
   logic          BUS_CS = 1'b0;
   logic [31:0]   BUS_RDATA;
   logic [AW-1:0] SRAM_ADDR;
   logic [31:0]   SRAM_WDATA;
   logic [3:0]    SRAM_WREN;
   logic          SRAM_CS;
   logic [31:0]   sram_rdata;
   logic          SPI_CS_N;
   logic          SPI_SCLK;
   logic          SPI_MOSI;
   logic          fl_miso = 1'b0;
   logic          PRELOAD_BUSY;
   logic          PRELOAD_DONE;
   logic [31:0]   PRELOAD_CSUM;

   int n_vec     = 0;
   int n_miscmp  = 0;
   int n_ld_wr   = 0;
   int n_done_rise = 0;

   wr_t         wr_q[$];
   logic [31:0] rd_q[$];

   always #5 CLK = ~CLK;

   fpga_sram_spi_preload #(
      .AW         (AW),
      .FLASH_BASE (FLASH_BASE),
      .CLKDIV     (CLKDIV)
   ) u_dut (
      .CLK          (CLK),
      .RESETn       (RESETn),
      .BUS_ADDR     (BUS_ADDR),
      .BUS_WDATA    (BUS_WDATA),
      .BUS_WREN     (BUS_WREN),
      .BUS_CS       (BUS_CS),
      .BUS_RDATA    (BUS_RDATA),
      .SRAM_ADDR    (SRAM_ADDR),
      .SRAM_WDATA   (SRAM_WDATA),
      .SRAM_WREN    (SRAM_WREN),
      .SRAM_CS      (SRAM_CS),
      .SRAM_RDATA   (sram_rdata),
      .SPI_CS_N     (SPI_CS_N),
      .SPI_SCLK     (SPI_SCLK),
      .SPI_MOSI     (SPI_MOSI),
      .SPI_MISO     (fl_miso),
      .PRELOAD_BUSY (PRELOAD_BUSY),
      .PRELOAD_DONE (PRELOAD_DONE),
      .PRELOAD_CSUM (PRELOAD_CSUM)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Flash image: byte at FLASH_BASE+k holds k, so word w is {4w+3,..,4w}.
   function automatic logic [31:0] exp_word(input int w);
      return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
   endfunction

   // ------------------------------------------------------------------------
   // SRAM model: registered read (new data on write), zero when not selected
   // ------------------------------------------------------------------------
   logic [31:0] sram_mem [NWORDS];

   always @(posedge CLK) begin
      if (SRAM_CS) begin
         for (int b = 0; b < 4; b++) begin
            if (SRAM_WREN[b]) sram_mem[SRAM_ADDR][8*b +: 8] = SRAM_WDATA[8*b +: 8];
         end
         sram_rdata <= sram_mem[SRAM_ADDR];
      end else begin
         sram_rdata <= 32'h0;
      end
   end

   // ------------------------------------------------------------------------
   // SPI flash model and SCLK phase checks (evaluated on falling CLK)
   // ------------------------------------------------------------------------
   int          fl_bits = 0;
   int          lo_run  = 0;
   int          hi_run  = 0;
   int          fl_idx;
   logic [31:0] fl_cmd  = 32'h0;
   logic [23:0] fl_addr;
   logic [7:0]  fl_byte;
   logic        fl_sclk_q = 1'b0;

   always @(negedge CLK) begin
      if (SPI_CS_N) begin
         fl_bits = 0;
         lo_run  = 0;
         hi_run  = 0;
         fl_miso = 1'b0;
      end else if (SPI_SCLK && !fl_sclk_q) begin
         if (fl_bits % 32 == 0) chk("sclk_lo_min", 32'(lo_run >= CLKDIV), 32'd1);
         else                   chk("sclk_lo", 32'(lo_run), 32'(CLKDIV));
         if (fl_bits < 32) fl_cmd = {fl_cmd[30:0], SPI_MOSI};
         else              chk("mosi_data_zero", 32'(SPI_MOSI), 32'd0);
         fl_bits++;
         if (fl_bits == 32) chk("flash_cmd", fl_cmd, {8'h03, FLASH_BASE});
         lo_run = 0;
         hi_run = 1;
      end else if (!SPI_SCLK && fl_sclk_q) begin
         chk("sclk_hi", 32'(hi_run), 32'(CLKDIV));
         hi_run = 0;
         lo_run = 1;
         if (fl_bits >= 32) begin
            fl_idx  = fl_bits - 32;
            fl_addr = fl_cmd[23:0] + 24'(fl_idx / 8);
            fl_byte = 8'(fl_addr - FLASH_BASE);
            fl_miso = fl_byte[7 - (fl_idx % 8)];
         end
      end else if (SPI_SCLK) begin
         hi_run++;
      end else begin
         lo_run++;
      end
      fl_sclk_q = SPI_SCLK;
   end

   // ------------------------------------------------------------------------
   // Loader write scoreboard and DONE edge counter
   // ------------------------------------------------------------------------
   wr_t  mon_e;
   logic done_q = 1'b0;

   always @(negedge CLK) begin
      if (RESETn && PRELOAD_BUSY && SRAM_CS) begin
         if (wr_q.size() == 0) begin
            chk("ld_unexpected_write", 32'd1, 32'd0);
         end else begin
            mon_e = wr_q.pop_front();
            chk("ld_addr", 32'(SRAM_ADDR), 32'(mon_e.addr));
            chk("ld_data", SRAM_WDATA, mon_e.data);
            chk("ld_wren", 32'(SRAM_WREN), 32'hF);
         end
         n_ld_wr++;
      end
      if (PRELOAD_DONE && !done_q) n_done_rise++;
      done_q = PRELOAD_DONE;
   end

   // ------------------------------------------------------------------------
   // Bus helpers (called at a falling CLK edge)
   // ------------------------------------------------------------------------
   task automatic bus_idle();
      BUS_CS    = 1'b0;
      BUS_WREN  = 4'h0;
      BUS_WDATA = 32'h0;
      BUS_ADDR  = '0;
   endtask

   task automatic bus_read(input string tag, input int addr, input logic [31:0] exp);
      BUS_CS   = 1'b1;
      BUS_WREN = 4'h0;
      BUS_ADDR = AW'(addr);
      rd_q.push_back(exp);
      @(negedge CLK);
      chk(tag, BUS_RDATA, rd_q.pop_front());
      bus_idle();
   endtask

   task automatic push_image();
      wr_t e;
      for (int w = 0; w < NWORDS; w++) begin
         e.addr = AW'(w);
         e.data = exp_word(w);
         wr_q.push_back(e);
      end
   endtask

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      int n;
      int wr_base;
      int done_base;
`ifdef FPGA_SRAM_PRELOAD_CSUM_EN
      logic [31:0] exp_csum;
`endif

      bus_idle();
      RESETn = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_cs_n",  32'(SPI_CS_N), 32'd1);
      chk("rst_sclk",  32'(SPI_SCLK), 32'd0);
      chk("rst_mosi",  32'(SPI_MOSI), 32'd0);
      chk("rst_busy",  32'(PRELOAD_BUSY), 32'd1);
      chk("rst_done",  32'(PRELOAD_DONE), 32'd0);
      chk("rst_csum",  PRELOAD_CSUM, 32'h0);
      chk("rst_sram_cs",   32'(SRAM_CS), 32'd0);
      chk("rst_sram_wren", 32'(SRAM_WREN), 32'd0);
      chk("rst_rdata", BUS_RDATA, 32'h0);

      // First load, aborted by reset partway through.
      push_image();
      RESETn = 1'b1;
      repeat (10) @(negedge CLK);
      BUS_CS    = 1'b1;
      BUS_ADDR  = AW'(5);
      BUS_WREN  = 4'hF;
      BUS_WDATA = 32'hDEADBEEF;
      #1;
      chk("busy_bus_sram_cs", 32'(SRAM_CS), 32'd0);
      rd_q.push_back(32'h0);
      @(negedge CLK);
      chk("busy_bus_rdata", BUS_RDATA, rd_q.pop_front());
      bus_idle();

      n = 0;
      while (n_ld_wr < 7 && n < 20000) begin
         @(negedge CLK);
         n++;
      end
      chk("reach_word7", 32'(n < 20000), 32'd1);
      n = 0;
      while (!SPI_SCLK && n < 1000) begin
         @(negedge CLK);
         n++;
      end
      chk("sclk_high_before_rst", 32'(SPI_SCLK), 32'd1);
      #2 RESETn = 1'b0;
      #1;
      chk("midrst_cs_n", 32'(SPI_CS_N), 32'd1);
      chk("midrst_sclk", 32'(SPI_SCLK), 32'd0);
      chk("midrst_busy", 32'(PRELOAD_BUSY), 32'd1);
      wr_q.delete();
      repeat (2) @(negedge CLK);

      // Full load from word 0.
      push_image();
      wr_base   = n_ld_wr;
      done_base = n_done_rise;
      RESETn    = 1'b1;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!PRELOAD_DONE && n < 20000);
      chk("done_latency", 32'(n), 32'(LOAD_CYCLES));
      chk("done_no_leak", BUS_RDATA, 32'h0);
      chk("done_cs_n", 32'(SPI_CS_N), 32'd1);
      chk("done_sclk", 32'(SPI_SCLK), 32'd0);
      chk("done_busy", 32'(PRELOAD_BUSY), 32'd0);

      // Access on the very first DONE cycle must be honoured.
      bus_read("rd_first_done_w15", 15, exp_word(15));
      bus_read("rd_w5", 5, 32'h17161514);
      bus_read("rd_w0", 0, 32'h03020100);

      BUS_CS    = 1'b1;
      BUS_ADDR  = AW'(3);
      BUS_WREN  = 4'b0010;
      BUS_WDATA = 32'h0000AB00;
      @(negedge CLK);
      bus_idle();
      bus_read("rd_w3_after_byte_wr", 3, 32'h0F0EAB0C);
      for (int w = 6; w < NWORDS; w += 3) begin
         bus_read("rd_image", w, exp_word(w));
      end

      repeat (20) @(negedge CLK);
      chk("ld_write_count", 32'(n_ld_wr - wr_base), 32'(NWORDS));
      chk("ld_queue_empty", 32'(wr_q.size()), 32'd0);
      chk("done_rise_once", 32'(n_done_rise - done_base), 32'd1);
      chk("done_hold", 32'(PRELOAD_DONE), 32'd1);
      chk("done_cs_n_hold", 32'(SPI_CS_N), 32'd1);
`ifdef FPGA_SRAM_PRELOAD_CSUM_EN
      exp_csum = 32'h0;
      for (int w = 0; w < NWORDS; w++) exp_csum += exp_word(w);
      chk("csum", PRELOAD_CSUM, exp_csum);
`else
      chk("csum_tied_zero", PRELOAD_CSUM, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
`default_nettype wire
